count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, count and limit width in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous and active-low.
REQ-004 tick  input  1  one-clk-wide step enable from the frequency divider; one step per tick.
REQ-005 start  input  1  synchronous command pulse: begin or resume counting.
REQ-006 stop  input  1  synchronous command pulse: pause, or abort to idle.
REQ-007 mode  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up.
REQ-008 limit  input  WIDTH  terminal count value.
REQ-009 count  output  WIDTH  current count value, registered.
REQ-010 dir  output  1  current direction, 1 = up, 0 = down, registered.
REQ-011 running  output  1  high only in state RUN.
REQ-012 done  output  1  high only in state DONE.

Function
REQ-013 States SHALL be IDLE, RUN, PAUSE, DONE.
REQ-014 mode and limit SHALL be latched only on the IDLE->RUN or DONE->RUN transition; later changes are ignored until the next such transition.
REQ-015 IDLE + start: go to RUN; count loads latched limit with dir=0 for mode 01; count loads 0 with dir=1 for all other modes.
REQ-016 Ticks SHALL advance count only in RUN; count changes on the clk edge at which tick is sampled high (latency 1 clk).
REQ-017 A tick coincident with the start transition SHALL be ignored; the first step uses the next tick.
REQ-018 Mode 00: count +1 per tick; count==limit -> 0 on the next tick.
REQ-019 Mode 01: count -1 per tick; count==0 -> limit on the next tick.
REQ-020 Mode 10: dir=1 at count==limit -> count=limit-1 and dir=0 on the same edge; dir=0 at count==0 -> count=1 and dir=1 on the same edge.
REQ-021 Mode 11: count +1 per tick; tick at count==limit -> DONE, with count held at limit.
REQ-022 limit==0 in any mode: count SHALL remain 0 and dir SHALL remain constant; mode 11 enters DONE on the first tick.
REQ-023 limit==2^WIDTH-1: wrap and turn-around SHALL follow REQ-018..021 with no overflow.
REQ-024 RUN + stop: go to PAUSE; count and dir held.
REQ-025 PAUSE + start: return to RUN with count and dir unchanged and no re-latch.
REQ-026 PAUSE + stop: go to IDLE.
REQ-027 DONE + start: go to RUN, re-latch mode and limit, and reload per REQ-015.
REQ-028 DONE + stop: go to IDLE.
REQ-029 start and stop asserted in the same cycle: stop SHALL win.
REQ-030 stop and tick asserted in the same cycle in RUN: no step, go to PAUSE.
REQ-031 On entry to IDLE, count SHALL be 0 and dir SHALL be 1.
REQ-032 start in RUN and stop in IDLE SHALL be ignored.

Reset
REQ-033 nrst low SHALL immediately force IDLE, count=0, dir=1, running=0, done=0, and clear latched mode/limit to 0, irrespective of clk.
REQ-034 Reset asserted mid-RUN SHALL abort without completing a step; after release, the block SHALL wait for start.

Verification
REQ-035 mode=00, limit=5, start, then 8 ticks -> count 1,2,3,4,5,0,1,2; running=1.
REQ-036 mode=10, limit=3, start, then 8 ticks -> count 1,2,3,2,1,0,1,2; dir falls on the edge count becomes 2 after 3, and rises on the edge count becomes 1 after 0.
REQ-037 mode=11, limit=2, start, then 4 ticks -> count 1,2, then DONE with done=1 and count=2 held; start -> count=0 and RUN.
REQ-038 mode=01, limit=4, start, 2 ticks (count=2), stop with tick in the same cycle -> PAUSE with count=2; 3 ticks -> count stays 2; start, 1 tick -> count=1.
REQ-039 Start and stop pulsed together from RUN -> PAUSE; stop again -> IDLE with count=0.
REQ-040 nrst pulsed asynchronously between clk edges mid-RUN with count=3 -> outputs go to the reset values of REQ-033 before the next edge; ticks ignored until start.

Source files
------------

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - tick-driven up/down/ping-pong/one-shot counter with IDLE/RUN/PAUSE/DONE control
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] limit_q;

    logic [WIDTH-1:0] step_count_d;
    logic             step_dir_d;
    logic             step_done_d;
    logic [WIDTH-1:0] load_count_d;
    logic             load_dir_d;

    // Next count/dir for one tick, using only the latched mode and limit.
    always_comb begin
        step_count_d = count_q;
        step_dir_d   = dir_q;
        step_done_d  = 1'b0;
        case (mode_q)
            MODE_UP:   step_count_d = (count_q == limit_q) ? '0 : count_q + WIDTH'(1);
            MODE_DOWN: step_count_d = (count_q == '0) ? limit_q : count_q - WIDTH'(1);
            MODE_PING: begin
                if (limit_q != '0) begin
                    if (dir_q) begin
                        if (count_q == limit_q) begin
                            step_count_d = limit_q - WIDTH'(1);
                            step_dir_d   = 1'b0;
                        end else begin
                            step_count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        if (count_q == '0) begin
                            step_count_d = WIDTH'(1);
                            step_dir_d   = 1'b1;
                        end else begin
                            step_count_d = count_q - WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                if (count_q == limit_q) step_done_d = 1'b1;
                else                    step_count_d = count_q + WIDTH'(1);
            end
        endcase
    end

    // Reload values come from the live inputs because they are latched on the same edge.
    always_comb begin
        load_count_d = (mode == MODE_DOWN) ? limit : '0;
        load_dir_d   = (mode != MODE_DOWN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            count_q <= '0;
            dir_q   <= 1'b1;
            mode_q  <= '0;
            limit_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        dir_q   <= 1'b1;
                    end else if (start) begin
                        state_q <= RUN;
                        mode_q  <= mode;
                        limit_q <= limit;
                        count_q <= load_count_d;
                        dir_q   <= load_dir_d;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= PAUSE;
                    end else if (tick) begin
                        count_q <= step_count_d;
                        dir_q   <= step_dir_d;
                        if (step_done_d) state_q <= DONE;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        dir_q   <= 1'b1;
                    end else if (start) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed self-checking bench for count_sequencer
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       tick, start, stop;
    logic [1:0] mode;
    logic [3:0] limit;
    logic [3:0] count;
    logic       dir, running, done;

    int total = 0;
    int bad   = 0;

    count_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .nrst(nrst), .tick(tick), .start(start), .stop(stop),
        .mode(mode), .limit(limit), .count(count), .dir(dir),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic t, input logic s, input logic p);
        tick = t; start = s; stop = p;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b0; tick = 0; start = 0; stop = 0; mode = 2'b00; limit = 4'd0;
        #12;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if ({dir, running, done} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b want=100", {dir, running, done}); end
        @(negedge clk); nrst = 1'b1;
        cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 0);
        total++; if ({count, running} !== 5'b0000_0) begin bad++; $display("FAIL idle_ignores_tick got=%b want=00000", {count, running}); end
    endtask

    task automatic test_up_wrap;
        logic [3:0] exp [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
        mode = 2'b00; limit = 4'd5;
        cyc(0, 1, 0);
        total++; if ({running, dir, count} !== 6'b11_0000) begin bad++; $display("FAIL up_start got=%b want=110000", {running, dir, count}); end
        mode = 2'b01; limit = 4'd2;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0);
            total++; if (count !== exp[i] || running !== 1'b1) begin bad++; $display("FAIL up_tick%0d got=%0d/%b want=%0d/1", i, count, running, exp[i]); end
        end
        cyc(0, 0, 1); cyc(0, 0, 1);
    endtask

    task automatic test_ping_pong;
        logic [3:0] exp_c [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
        logic       exp_d [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        mode = 2'b10; limit = 4'd3;
        cyc(0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0);
            total++; if (count !== exp_c[i] || dir !== exp_d[i]) begin bad++; $display("FAIL ping_tick%0d got=%0d/%b want=%0d/%b", i, count, dir, exp_c[i], exp_d[i]); end
        end
        cyc(0, 0, 1); cyc(0, 0, 1);
    endtask

    task automatic test_one_shot;
        logic [3:0] exp_c [4] = '{1, 2, 2, 2};
        logic       exp_f [4] = '{0, 0, 1, 1};
        mode = 2'b11; limit = 4'd2;
        cyc(1, 1, 0);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL oneshot_start_tick_ignored got=%0d want=0", count); end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            total++; if (count !== exp_c[i] || done !== exp_f[i] || running !== !exp_f[i]) begin
                bad++; $display("FAIL oneshot_tick%0d got=%0d/d%b/r%b want=%0d/d%b", i, count, done, running, exp_c[i], exp_f[i]);
            end
        end
        cyc(0, 1, 0);
        total++; if ({count, running, done} !== 6'b0000_10) begin bad++; $display("FAIL oneshot_restart got=%b want=000010", {count, running, done}); end
        cyc(0, 0, 1); cyc(0, 0, 1);
        total++; if ({count, dir, running} !== 6'b0000_10) begin bad++; $display("FAIL oneshot_to_idle got=%b want=000010", {count, dir, running}); end
    endtask

    task automatic test_down_pause;
        mode = 2'b01; limit = 4'd4;
        cyc(0, 1, 0);
        total++; if (count !== 4'd4 || dir !== 1'b0) begin bad++; $display("FAIL down_load got=%0d/%b want=4/0", count, dir); end
        cyc(1, 0, 0); cyc(1, 0, 0);
        cyc(1, 0, 1);
        total++; if (count !== 4'd2 || running !== 1'b0) begin bad++; $display("FAIL down_stop_tick got=%0d/%b want=2/0", count, running); end
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL pause_hold got=%0d want=2", count); end
        mode = 2'b00; limit = 4'd9;
        cyc(0, 1, 0);
        total++; if (count !== 4'd2 || running !== 1'b1 || dir !== 1'b0) begin bad++; $display("FAIL resume got=%0d/%b/%b want=2/1/0", count, running, dir); end
        cyc(1, 0, 0);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL resume_step got=%0d want=1", count); end
        cyc(1, 1, 0); cyc(1, 0, 0);
        total++; if (count !== 4'd4 || running !== 1'b1) begin bad++; $display("FAIL down_wrap got=%0d/%b want=4/1", count, running); end
        cyc(0, 0, 1); cyc(0, 0, 1);
    endtask

    task automatic test_start_stop;
        mode = 2'b00; limit = 4'd7;
        cyc(0, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        cyc(0, 1, 1);
        total++; if ({count, running, done} !== 6'b0010_00) begin bad++; $display("FAIL startstop_pause got=%b want=001000", {count, running, done}); end
        cyc(0, 0, 1);
        total++; if ({count, dir, running} !== 6'b0000_10) begin bad++; $display("FAIL pause_stop_idle got=%b want=000010", {count, dir, running}); end
        cyc(0, 1, 1);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_startstop got=%b want=0", running); end
    endtask

    task automatic test_async_reset;
        mode = 2'b00; limit = 4'd9;
        cyc(0, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL pre_reset got=%0d want=3", count); end
        tick = 1'b1;
        #3 nrst = 1'b0;
        #1;
        total++; if ({count, dir, running, done} !== 7'b0000_100) begin bad++; $display("FAIL async_reset got=%b want=0000100", {count, dir, running, done}); end
        #2 nrst = 1'b1;
        tick = 1'b0;
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        total++; if ({count, running} !== 5'b0000_0) begin bad++; $display("FAIL post_reset_idle got=%b want=00000", {count, running}); end
        cyc(0, 1, 0); cyc(1, 0, 0);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL post_reset_run got=%0d want=1", count); end
        cyc(0, 0, 1); cyc(0, 0, 1);
    endtask

    task automatic test_limits;
        mode = 2'b10; limit = 4'd0;
        cyc(0, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        total++; if (count !== 4'd0 || dir !== 1'b1) begin bad++; $display("FAIL ping_limit0 got=%0d/%b want=0/1", count, dir); end
        cyc(0, 0, 1); cyc(0, 0, 1);
        mode = 2'b11; limit = 4'd0;
        cyc(0, 1, 0); cyc(1, 0, 0);
        total++; if (count !== 4'd0 || done !== 1'b1) begin bad++; $display("FAIL oneshot_limit0 got=%0d/%b want=0/1", count, done); end
        cyc(0, 0, 1);
        mode = 2'b00; limit = 4'd15;
        cyc(0, 1, 0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 0);
        total++; if (count !== 4'd15) begin bad++; $display("FAIL up_max got=%0d want=15", count); end
        cyc(1, 0, 0);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL up_max_wrap got=%0d want=0", count); end
        cyc(0, 0, 1); cyc(0, 0, 1);
        mode = 2'b10; limit = 4'd15;
        cyc(0, 1, 0);
        for (int i = 0; i < 15; i++) cyc(1, 0, 0);
        total++; if (count !== 4'd15 || dir !== 1'b1) begin bad++; $display("FAIL ping_max got=%0d/%b want=15/1", count, dir); end
        cyc(1, 0, 0);
        total++; if (count !== 4'd14 || dir !== 1'b0) begin bad++; $display("FAIL ping_max_turn got=%0d/%b want=14/0", count, dir); end
        cyc(0, 0, 1); cyc(0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_ping_pong();
        test_one_shot();
        test_down_pause();
        test_start_stop();
        test_async_reset();
        test_limits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
